ds_spi_poller: RTL
==================

// Module: ds_spi_poller
// PURPOSE
//  Periodically polls a PlayStation DualShock pad over its 4-wire SPI-like bus and
//  publishes the raw active-low button bytes to ds2snes, which serialises them onto
//  the SNES joypad port. Feeds it directly: rx0 = (L D R U St R3 L3 Se), rx1 = (□ X O △ R1 L1 R2 L2).
// PARAMETERS
//  FREQ     21_600_000  clk frequency in Hz
//  SCK_HZ   250_000     ds_clk bit rate; HALF = FREQ/(2*SCK_HZ) clk cycles per half-bit (>=2)
//  POLL_HZ  60          frame start rate; PERIOD = FREQ/POLL_HZ clk cycles
//  GAP_US   20          idle time between bytes and CS setup/hold, in microseconds
// PORTS
//  clk        in   1  system clock
//  resetn     in   1  synchronous reset, active low
//  ds_clk     out  1  pad clock, idles high
//  ds_cs      out  1  pad select (ATT), active low
//  ds_mosi    out  1  command data to pad, LSB first
//  ds_miso    in   1  response data from pad, LSB first
//  rx0        out  8  button byte 0, active low (1 = released)
//  rx1        out  8  button byte 1, active low
//  pad_id     out  8  byte-1 response of last good frame (0x41 digital, 0x73 analog)
//  present    out  1  last frame was good
//  frame_vld  out  1  one-cycle pulse when a frame completes (good or bad)
// BEHAVIOUR
//  - Reset: ds_clk=1, ds_cs=1, ds_mosi=1, rx0=rx1=8'hFF, pad_id=0, present=0,
//    frame_vld=0, FSM=IDLE, period counter=0. Reset mid-frame aborts at once, no frame_vld.
//  - Command bytes: 0x01, 0x42, then 0x00 for remaining bytes. NBYTES=5 (9 with ANALOG_EN).
//  - FSM: IDLE -(period counter hits PERIOD-1)-> SETUP: ds_cs=0, wait GAP -> BIT_LO: ds_clk=0,
//    ds_mosi=cmd[bit], hold HALF -> BIT_HI: ds_clk=1, sample ds_miso on the first cycle of
//    BIT_HI into shift reg MSB (shift right), hold HALF; after bit 7 -> GAP (ds_clk=1,
//    ds_mosi=1, GAP) -> next byte BIT_LO, or after last byte -> HOLD: wait GAP, ds_cs=1 -> DONE
//    (1 cycle) -> IDLE. Period counter free-runs from reset, independent of FSM.
//  - ACK line is not used; fixed GAP replaces it.
//  - Good frame: byte1 high nibble in {4,7} AND byte2 == 0x5A. On DONE of a good frame:
//    rx0<=byte3, rx1<=byte4, pad_id<=byte1, present<=1. Bad frame: rx0=rx1<=8'hFF
//    (all released), present<=0, pad_id unchanged. frame_vld=1 in DONE only.
//  - Outputs change only in DONE; stable for whole poll period (no mid-frame tearing).
//  - Period tick while frame in progress: ignored (no queueing); next frame on next tick.
//  - miso floating high (no pad) -> byte2=0xFF -> bad frame -> buttons released.
// CONFIGURATION
//  DS_ANALOG_EN defined: NBYTES=9; extra outputs rx_rx, rx_ry, rx_lx, rx_ly (8 bits each,
//    reset 8'h80) updated from bytes 5..8 on good frames with pad_id==0x73; forced to 8'h80
//    on bad frames or digital pads.
//  Not defined: NBYTES=5, no stick ports, frame length 5 bytes.
// TESTING
//  1 reset held 3 cycles mid-frame -> ds_cs=1, ds_clk=1, rx0=rx1=FF, present=0 next cycle.
//  2 pad model returns FF 41 5A FE BF -> after DONE rx0=FE, rx1=BF, pad_id=41, present=1,
//    one frame_vld pulse; mosi decoded as 01 42 00 00 00 LSB first.
//  3 miso tied high -> frame_vld pulse, present=0, rx0=rx1=FF.
//  4 good frame then byte2=0x5B -> rx0/rx1 revert to FF, pad_id keeps 41.
//  5 FREQ=1_000_000, SCK_HZ=250_000, POLL_HZ=1000 -> ds_clk low/high 2 cycles each,
//    ds_cs falls every 1000 cycles, exactly 40 (or 72 analog) rising edges per frame.
//  6 DS_ANALOG_EN, model FF 73 5A FF FF 10 20 30 40 -> rx_rx=10, rx_ry=20, rx_lx=30,
//    rx_ly=40; then 41-ID frame -> all sticks 80.

Source files
------------

// File: rtl/ds_spi_poller.sv
// DualShock pad poller: periodically clocks a 0x01 0x42 0x00.. command frame out and
// latches the button bytes on good frames. Define DS_ANALOG_EN for 9-byte frames with stick outputs.
module ds_spi_poller #(
    parameter int FREQ    = 21_600_000,
    parameter int SCK_HZ  = 250_000,
    parameter int POLL_HZ = 60,
    parameter int GAP_US  = 20
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       ds_clk,
    output logic       ds_cs,
    output logic       ds_mosi,
    input  logic       ds_miso,
    output logic [7:0] rx0,
    output logic [7:0] rx1,
    output logic [7:0] pad_id,
    output logic       present,
    output logic       frame_vld
`ifdef DS_ANALOG_EN
    ,
    output logic [7:0] rx_rx,
    output logic [7:0] rx_ry,
    output logic [7:0] rx_lx,
    output logic [7:0] rx_ly
`endif
);

    localparam int HALF    = FREQ / (2 * SCK_HZ);
    localparam int PERIOD  = FREQ / POLL_HZ;
    localparam int GAP     = ((FREQ / 1000) * GAP_US) / 1000;
`ifdef DS_ANALOG_EN
    localparam int NBYTES  = 9;
`else
    localparam int NBYTES  = 5;
`endif
    localparam int DLY_MAX = (GAP > HALF) ? GAP : HALF;
    localparam int CW      = $clog2(DLY_MAX + 1);
    localparam int PW      = $clog2(PERIOD);
    localparam int BW      = $clog2(NBYTES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_BIT_LO = 3'd2;
    localparam logic [2:0] S_BIT_HI = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [PW-1:0]           per_q, per_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              bit_q, bit_d;
    logic [BW-1:0]           byte_q, byte_d;
    logic [7:0]              shift_q, shift_d;
    // Byte 0 of the response carries nothing useful, so only bytes 1.. are kept.
    logic [NBYTES-1:1][7:0]  frame_q, frame_d;
    logic                    sck_q, sck_d, cs_q, cs_d, mosi_q, mosi_d;
    logic [7:0]              rx0_q, rx0_d, rx1_q, rx1_d, id_q, id_d;
    logic                    present_q, present_d, vld_q, vld_d;
    logic                    tick, good;
    logic [7:0]              cmd_cur;
`ifdef DS_ANALOG_EN
    logic [3:0][7:0]         stick_q, stick_d;
`endif

    function automatic logic [7:0] cmd_byte(input logic [BW-1:0] idx);
        if (idx == BW'(0))      return 8'h01;
        else if (idx == BW'(1)) return 8'h42;
        else                    return 8'h00;
    endfunction

    assign tick = (per_q == PW'(PERIOD - 1));
    assign per_d = tick ? '0 : per_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        frame_d   = frame_q;
        sck_d     = sck_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        rx0_d     = rx0_q;
        rx1_d     = rx1_q;
        id_d      = id_q;
        present_d = present_q;
        vld_d     = 1'b0;
`ifdef DS_ANALOG_EN
        stick_d   = stick_q;
`endif
        cmd_cur   = cmd_byte(byte_q);
        good      = ((frame_q[1][7:4] == 4'h4) || (frame_q[1][7:4] == 4'h7))
                    && (frame_q[2] == 8'h5A);
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_SETUP;
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    byte_d  = '0;
                end
            end
            S_SETUP, S_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    state_d = S_BIT_LO;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b0;
                    mosi_d  = cmd_cur[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BIT_LO: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    state_d = S_BIT_HI;
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BIT_HI: begin
                if (cnt_q == '0)
                    shift_d = {ds_miso, shift_q[7:1]};
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        if (byte_q != BW'(0))
                            frame_d[byte_q] = shift_d;
                        mosi_d = 1'b1;
                        if (byte_q == BW'(NBYTES - 1)) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_GAP;
                            byte_d  = byte_q + 1'b1;
                        end
                    end else begin
                        state_d = S_BIT_LO;
                        bit_d   = bit_q + 3'd1;
                        sck_d   = 1'b0;
                        mosi_d  = cmd_cur[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    state_d = S_DONE;
                    cs_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                vld_d   = 1'b1;
                if (good) begin
                    rx0_d     = frame_q[3];
                    rx1_d     = frame_q[4];
                    id_d      = frame_q[1];
                    present_d = 1'b1;
                end else begin
                    rx0_d     = 8'hFF;
                    rx1_d     = 8'hFF;
                    present_d = 1'b0;
                end
`ifdef DS_ANALOG_EN
                for (int k = 0; k < 4; k++)
                    stick_d[k] = (good && frame_q[1] == 8'h73) ? frame_q[5 + k] : 8'h80;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            per_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            shift_q   <= '0;
            frame_q   <= '0;
            sck_q     <= 1'b1;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b1;
            rx0_q     <= 8'hFF;
            rx1_q     <= 8'hFF;
            id_q      <= 8'h00;
            present_q <= 1'b0;
            vld_q     <= 1'b0;
`ifdef DS_ANALOG_EN
            stick_q   <= {4{8'h80}};
`endif
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            frame_q   <= frame_d;
            sck_q     <= sck_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            rx0_q     <= rx0_d;
            rx1_q     <= rx1_d;
            id_q      <= id_d;
            present_q <= present_d;
            vld_q     <= vld_d;
`ifdef DS_ANALOG_EN
            stick_q   <= stick_d;
`endif
        end
    end

    assign ds_clk    = sck_q;
    assign ds_cs     = cs_q;
    assign ds_mosi   = mosi_q;
    assign rx0       = rx0_q;
    assign rx1       = rx1_q;
    assign pad_id    = id_q;
    assign present   = present_q;
    assign frame_vld = vld_q;
`ifdef DS_ANALOG_EN
    assign rx_rx = stick_q[0];
    assign rx_ry = stick_q[1];
    assign rx_lx = stick_q[2];
    assign rx_ly = stick_q[3];
`endif

endmodule
